fp_greater_equal: RTL and testbench



---
 rtl/fp_greater_equal.sv | 84 ++++++++
 tb/tb_fp_greater_equal.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_greater_equal.sv
// Two-stage pipelined IEEE-754 binary32 "value1 >= value2" comparator.
// Stage 1 classifies operands and compares magnitudes; stage 2 resolves the decision.
module fp_greater_equal (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] value1,
  input  logic [31:0] value2,
  output logic [31:0] result
);

  // Stage 1 state
  logic any_nan_d, any_nan_q;
  logic both_zero_d, both_zero_q;
  logic sign1_d, sign1_q;
  logic sign2_d, sign2_q;
  logic mag_ge_d, mag_ge_q;
  logic mag_le_d, mag_le_q;

  // Stage 2 state
  logic ge_d, ge_q;

  logic [7:0]  exp1, exp2;
  logic [22:0] man1, man2;
  logic        nan1, nan2;
  logic        zero1, zero2;

  always_comb begin
    exp1  = value1[30:23];
    exp2  = value2[30:23];
    man1  = value1[22:0];
    man2  = value2[22:0];
    nan1  = (&exp1) && (|man1);
    nan2  = (&exp2) && (|man2);
    zero1 = ~(|value1[30:0]);
    zero2 = ~(|value2[30:0]);

    any_nan_d   = nan1 | nan2;
    both_zero_d = zero1 & zero2;
    sign1_d     = value1[31];
    sign2_d     = value2[31];
    // Sign-magnitude encoding orders same-sign values by their low 31 bits,
    // including denormals and infinities.
    mag_ge_d    = value1[30:0] >= value2[30:0];
    mag_le_d    = value1[30:0] <= value2[30:0];
  end

  always_comb begin
    ge_d = 1'b0;
    if (any_nan_q) begin
      ge_d = 1'b0;
    end else if (both_zero_q) begin
      ge_d = 1'b1;
    end else if (sign1_q != sign2_q) begin
      ge_d = ~sign1_q;
    end else if (!sign1_q) begin
      ge_d = mag_ge_q;
    end else begin
      ge_d = mag_le_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      any_nan_q   <= 1'b0;
      both_zero_q <= 1'b0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      mag_ge_q    <= 1'b0;
      mag_le_q    <= 1'b0;
      ge_q        <= 1'b0;
    end else begin
      any_nan_q   <= any_nan_d;
      both_zero_q <= both_zero_d;
      sign1_q     <= sign1_d;
      sign2_q     <= sign2_d;
      mag_ge_q    <= mag_ge_d;
      mag_le_q    <= mag_le_d;
      ge_q        <= ge_d;
    end
  end

  assign result = {31'b0, ge_q};

endmodule

// File: tb/tb_fp_greater_equal.sv
// Scoreboard bench for fp_greater_equal: stimulus pushes expected results,
// a negedge monitor pops and compares them when the 2-cycle pipeline delivers.
module tb_fp_greater_equal;

  logic        aclk;
  logic        areset;
  logic [31:0] value1;
  logic [31:0] value2;
  logic [31:0] result;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } item_t;

  item_t exp_q[$];
  logic  issue;
  logic  vld_p1, vld_p2;
  int    n_cmp, n_err;

  fp_greater_equal dut (
    .aclk   (aclk),
    .areset (areset),
    .value1 (value1),
    .value2 (value2),
    .result (result)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Independent reference: map each float onto a signed ordering key.
  function automatic logic [31:0] ref_ge(input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] ka, kb;
    if ((a[30:23] == 8'hff && a[22:0] != 0) || (b[30:23] == 8'hff && b[22:0] != 0))
      return 32'h0;
    ka = a[31] ? -$signed({2'b00, a[30:0]}) : $signed({2'b00, a[30:0]});
    kb = b[31] ? -$signed({2'b00, b[30:0]}) : $signed({2'b00, b[30:0]});
    return (ka >= kb) ? 32'h1 : 32'h0;
  endfunction

  // Tracks which cycles carry a real pair; a reset flushes both the pipe and its expectations.
  always @(posedge aclk) begin
    if (areset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      exp_q.delete();
    end else begin
      vld_p1 <= issue;
      vld_p2 <= vld_p1;
    end
  end

  always @(negedge aclk) begin
    item_t it;
    if (vld_p2) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_underflow: got %h, required no output", result);
      end else begin
        it = exp_q.pop_front();
        chk($sformatf("ge(%h,%h)", it.a, it.b), result, it.exp);
      end
    end
  end

  // Applies a pair for exactly one cycle; returns 1 time unit after the capturing edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    item_t it;
    value1 = a;
    value2 = b;
    issue  = 1'b1;
    it.a = a;
    it.b = b;
    it.exp = e;
    exp_q.push_back(it);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    issue = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    n_cmp  = 0;
    n_err  = 0;
    issue  = 1'b0;
    areset = 1'b1;

    // Reset held for 3 edges; first edge sees undriven operands.
    @(posedge aclk);
    #1;
    chk("reset_edge1", result, 32'h0);
    value1 = 32'h40200000;
    value2 = 32'h3fc00000;
    @(posedge aclk);
    #1;
    chk("reset_edge2", result, 32'h0);
    @(posedge aclk);
    #1;
    chk("reset_edge3", result, 32'h0);

    areset = 1'b0;
    drive(32'h40200000, 32'h3fc00000, 32'h1);
    chk("post_release_edge1", result, 32'h0);

    // Directed vectors, back to back.
    drive(32'h3fc00000, 32'h40200000, 32'h0);
    drive(32'h3fc00000, 32'h3fc00000, 32'h1);
    drive(32'h40200000, 32'h3fc00000, 32'h1);
    drive(32'h80000000, 32'h00000000, 32'h1);
    drive(32'h00000000, 32'h80000000, 32'h1);
    drive(32'hbf800000, 32'h3f800000, 32'h0);
    drive(32'h3f800000, 32'hbf800000, 32'h1);
    drive(32'hc0000000, 32'hc0400000, 32'h1);
    drive(32'hc0400000, 32'hc0000000, 32'h0);
    drive(32'h7fc00000, 32'h3f800000, 32'h0);
    drive(32'h3f800000, 32'h7fc00000, 32'h0);
    drive(32'h7f800000, 32'h7f7fffff, 32'h1);
    drive(32'hff800000, 32'hff800000, 32'h1);
    drive(32'h00000001, 32'h00000000, 32'h1);
    drive(32'h00000000, 32'h00000001, 32'h0);
    drive(32'h7f800001, 32'h7f800001, 32'h0);

    // Random back-to-back pairs against the reference model.
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case (i % 3)
        0: b = a;
        1: b = {1'($urandom), a[30:8], 8'($urandom)};
        default: b = $urandom;
      endcase
      drive(a, b, ref_ge(a, b));
    end

    // Mid-stream reset: two "1" results in flight get flushed.
    drive(32'h40200000, 32'h3fc00000, 32'h1);
    drive(32'h40200000, 32'h3fc00000, 32'h1);
    areset = 1'b1;
    drive(32'h40200000, 32'h3fc00000, 32'h1);
    chk("midstream_reset_edge", result, 32'h0);
    areset = 1'b0;
    drive(32'h3fc00000, 32'h40200000, 32'h0);
    chk("flush_no_stale", result, 32'h0);
    drive(32'h40200000, 32'h3fc00000, 32'h1);
    idle();
    idle();
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
